amiga_clk_ctrl: RTL

- Sits directly downstream of the PLL clock generator, in the 28 MHz chipset clock domain.
- Consumes the PLL lock flag and produces a stretched system reset plus all chipset timing enables.
- Timing enables: 7 MHz clock enables, 3.5 MHz quadrature c1/c3/cck phases, and the ~709 kHz E-clock (6 low / 4 high 7 MHz periods).
- Re-runs the reset sequence whenever lock is lost, and counts lock-loss events for diagnostics.

---
 rtl/amiga_clk_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/amiga_clk_ctrl.sv
// Chipset clock controller: PLL-lock synchronizer, stretched system reset, and
// 7 MHz / 3.5 MHz / E-clock timing enables derived from the 28 MHz clock.
module amiga_clk_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_CNT_W         = 11
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       sys_reset_n,
    output logic       clk7_en,
    output logic       clk7n_en,
    output logic       c1,
    output logic       c3,
    output logic       cck,
    output logic       eclk,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2
    } state_t;

    // The WAIT_LOCK cycle that sees lk_s counts toward the stable window,
    // so STABILIZE terminates one count early.
    localparam logic [LOCK_CNT_W-1:0] CNT_LAST = LOCK_CNT_W'(LOCK_STABLE_CYCLES - 2);

    logic                  lk_meta;
    logic                  lk_s;
    state_t                state;
    state_t                state_nxt;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic [LOCK_CNT_W-1:0] lock_cnt_nxt;
    logic [7:0]            loss_nxt;
    logic [2:0]            ph;
    logic [2:0]            ph_nxt;
    logic [3:0]            e_cnt;
    logic [3:0]            e_cnt_nxt;
    logic                  run_nxt;
    logic                  stay_run;

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        loss_nxt     = lock_loss_cnt;
        case (state)
            WAIT_LOCK: begin
                lock_cnt_nxt = '0;
                if (lk_s) state_nxt = STABILIZE;
            end
            STABILIZE: begin
                if (!lk_s) begin
                    state_nxt    = WAIT_LOCK;
                    lock_cnt_nxt = '0;
                end else if (lock_cnt == CNT_LAST) begin
                    state_nxt    = RUN;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_nxt = WAIT_LOCK;
                    if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = WAIT_LOCK;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Phase and E-counter advance only while RUN persists across the edge;
    // entering or leaving RUN forces them to 0 so outputs never glitch.
    always_comb begin
        run_nxt   = (state_nxt == RUN);
        stay_run  = (state == RUN) && run_nxt;
        ph_nxt    = stay_run ? ph + 3'd1 : 3'd0;
        e_cnt_nxt = 4'd0;
        if (stay_run) begin
            if (clk7_en) e_cnt_nxt = (e_cnt == 4'd9) ? 4'd0 : e_cnt + 4'd1;
            else         e_cnt_nxt = e_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lk_meta       <= 1'b0;
            lk_s          <= 1'b0;
            state         <= WAIT_LOCK;
            lock_cnt      <= '0;
            lock_loss_cnt <= 8'd0;
            ph            <= 3'd0;
            e_cnt         <= 4'd0;
            sys_reset_n   <= 1'b0;
            clk7_en       <= 1'b0;
            clk7n_en      <= 1'b0;
            c1            <= 1'b0;
            c3            <= 1'b0;
            cck           <= 1'b0;
            eclk          <= 1'b0;
        end else begin
            lk_meta       <= pll_locked;
            lk_s          <= lk_meta;
            state         <= state_nxt;
            lock_cnt      <= lock_cnt_nxt;
            lock_loss_cnt <= loss_nxt;
            ph            <= ph_nxt;
            e_cnt         <= e_cnt_nxt;
            sys_reset_n   <= run_nxt;
            clk7_en       <= run_nxt && (ph_nxt[1:0] == 2'd3);
            clk7n_en      <= run_nxt && (ph_nxt[1:0] == 2'd1);
            c1            <= run_nxt && !ph_nxt[2];
            c3            <= run_nxt && (ph_nxt[2] ^ ph_nxt[1]);
            cck           <= run_nxt && !ph_nxt[2];
            eclk          <= run_nxt && (e_cnt_nxt >= 4'd6);
        end
    end

endmodule
